// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch front end: PC control, imem requests, instruction FIFO to ID
// Optional feature macro: IF_MISALIGN_TRAP_EN (sticky misaligned-redirect flag, fetch parks until aligned redirect)
module if_fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        if_misalign
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ISSUE = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        stale, stale_nxt;
  logic [31:0] addr_nxt;
  logic [31:0] redirect_target;
  logic        accept;
  logic        push;
  logic        pop;
  logic        park;
  logic        can_issue;

  logic [31:0]   mem_instr [DEPTH];
  logic [31:0]   mem_pc    [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

`ifdef IF_MISALIGN_TRAP_EN
  // A misaligned target is still loaded into the PC; fetch parks instead of issuing it.
  assign redirect_target = redirect_pc;
  assign park            = if_misalign;

  // Sticky flag: set by a misaligned redirect, cleared only by the next aligned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_misalign <= 1'b0;
    end else if (redirect_valid) begin
      if_misalign <= |redirect_pc[1:0];
    end
  end
`else
  // Without the trap the low two bits are simply forced to word alignment.
  assign redirect_target = redirect_pc & ~32'd3;
  assign park            = 1'b0;
`endif

  // A request can only be launched when a FIFO slot is guaranteed for its response.
  // A redirect in the same cycle wins: pc_cur is about to change, so launching now would fetch a dead PC.
  assign can_issue      = (count < CW'(DEPTH)) && !park && !redirect_valid;
  assign imem_req_valid = (state == S_ISSUE);
  assign accept         = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid && !stale && !redirect_valid;
  assign pop            = id_valid && id_ready && !redirect_valid;

  // FSM state, stale marker and request address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      stale         <= 1'b0;
      imem_req_addr <= 32'd0;
    end else begin
      state         <= state_nxt;
      stale         <= stale_nxt;
      imem_req_addr <= addr_nxt;
    end
  end

  // Next-state logic: one outstanding request, address frozen from REQ until the response returns.
  always_comb begin
    state_nxt = state;
    stale_nxt = stale;
    addr_nxt  = imem_req_addr;
    case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        if (can_issue) begin
          addr_nxt  = pc_cur;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // The request cannot be withdrawn, so a redirect only marks its answer for disposal.
        if (redirect_valid) begin
          stale_nxt = 1'b1;
        end
        if (imem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A response coinciding with a redirect is dropped right here, so no stale marker is left behind.
        if (imem_rsp_valid) begin
          stale_nxt = 1'b0;
          state_nxt = S_REQ;
        end else if (redirect_valid) begin
          stale_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // PC register control: load on redirect, or advance past an accepted live request; hold otherwise.
  always_comb begin
    pc_hold = 1'b1;
    pc_next = 32'd0;
    if (redirect_valid) begin
      pc_hold = 1'b0;
      pc_next = redirect_target;
    end else if (accept && !stale) begin
      pc_hold = 1'b0;
      pc_next = imem_req_addr + 32'd4;
    end
  end

  // FIFO storage: instruction word tagged with the address it was fetched from.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= 32'd0;
        mem_pc[i]    <= 32'd0;
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= imem_rsp_data;
      mem_pc[wr_ptr]    <= imem_req_addr;
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Head of queue goes straight to ID; zeros when empty so ID never sees leftover entries.
  assign id_valid = (count != '0);
  assign id_instr = id_valid ? mem_instr[rd_ptr] : 32'd0;
  assign id_pc    = id_valid ? mem_pc[rd_ptr]    : 32'd0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_cur, pc_next;
  logic        pc_hold;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic [31:0] id_instr, id_pc;
  logic        id_ready;

  int tests = 0;
  int fails = 0;

  // environment knobs: 0 = always low, 1 = always high, 2 = random
  int ready_mode = 0;
  int idr_mode   = 0;
  int lat_fix    = 1;
  bit lat_rand   = 1'b0;

  int cyc = 0;
  int consumed = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend[$];
  logic [31:0] acc_log[$];

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_next;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  if_fetch_unit #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .pc_cur(pc_cur), .pc_next(pc_next), .pc_hold(pc_hold),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready)
  );

  // external PC register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_cur <= 32'd0;
    else if (!pc_hold) pc_cur <= pc_next;
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // instruction memory: accepts per ready_mode, answers after a latency, one response per request
  initial begin
    logic        acc_s, rsp_s;
    logic [31:0] a_s;
    int          l;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; id_ready = 1'b0;
    forever begin
      @(negedge clk);
      acc_s = imem_req_valid && imem_req_ready;
      rsp_s = imem_rsp_valid;
      a_s   = imem_req_addr;
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        pend.delete();
      end else begin
        if (rsp_s && pend.size() > 0) void'(pend.pop_front());
        if (acc_s) begin
          chk("one_outstanding", pend.size(), 0);
          l = lat_rand ? int'($urandom_range(1, 3)) : lat_fix;
          pend.push_back('{a_s, cyc + l - 1});
          acc_log.push_back(a_s);
        end
      end
      #1;
      imem_req_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 1) == 1);
      imem_rsp_valid = (pend.size() > 0) && (pend[0].due <= cyc);
      imem_rsp_data  = (pend.size() > 0) ? instr_of(pend[0].addr) : 32'd0;
      id_ready       = (idr_mode == 1) || (idr_mode == 2 && $urandom_range(0, 2) != 0);
    end
  end

  // reference model: ID must see the sequential stream starting at the last redirect target
  initial begin
    logic [31:0] exp_pc, prev_addr;
    bit          prev_redir, prev_stall;
    exp_pc = 32'd0; prev_addr = 32'd0; prev_redir = 1'b0; prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pc = 32'd0; prev_redir = 1'b0; prev_stall = 1'b0;
      end else begin
        if (prev_redir) chk("flush_after_redirect", id_valid, 0);
        if (prev_stall) begin
          chk("req_valid_held", imem_req_valid, 1);
          chk("req_addr_stable", imem_req_addr, prev_addr);
        end
        if (redirect_valid) begin
          exp_pc = redirect_pc & ~32'd3;
        end else if (id_valid && id_ready) begin
          chk("id_pc_order", id_pc, exp_pc);
          chk("id_instr", id_instr, instr_of(exp_pc));
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        prev_redir = redirect_valid;
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #2; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] t, input logic [31:0] exp_next);
    @(posedge clk); #2;
    redirect_valid = 1'b1; redirect_pc = t;
    @(negedge clk);
    chk("redirect_pc_hold", pc_hold, 0);
    chk("redirect_pc_next", pc_next, exp_next);
    @(posedge clk); #2;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_accept(output logic [31:0] a);
    int n = acc_log.size();
    int k = 0;
    while (acc_log.size() == n && k < 200) begin
      @(posedge clk); #2; k++;
    end
    chk("accept_seen", acc_log.size() > n, 1);
    a = (acc_log.size() > 0) ? acc_log[acc_log.size() - 1] : 32'hDEAD_BEEF;
  endtask

  task automatic wait_consumed(input int more);
    int target = consumed + more;
    int k = 0;
    while (consumed < target && k < 300) begin
      @(negedge clk); k++;
    end
    chk("progress", consumed >= target, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, a0, exp_next;
    int          last_acc, c0, n0, k;
    bit          seen;

    vecs[0] = '{32'h0000_0102, 32'h0000_0100};
    vecs[1] = '{32'h0000_0200, 32'h0000_0200};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[3] = '{32'h0000_0001, 32'h0000_0000};
    vecs[4] = '{32'h0000_0300, 32'h0000_0300};
    vecs[5] = '{32'h8000_0AB6, 32'h8000_0AB4};

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;

    // reset values, then first request two edges after release
    repeat (2) @(negedge clk);
    chk("rst_pc_hold", pc_hold, 1);
    chk("rst_pc_next", pc_next, 0);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk); chk("req_not_yet", imem_req_valid, 0);
    @(negedge clk); chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_addr, 0);

    // asynchronous reset while a request is outstanding and the FIFO holds an entry
    lat_fix = 5; ready_mode = 1; idr_mode = 0;
    wait_accept(a);
    wait_accept(a);
    @(negedge clk); #1;
    rst_n = 1'b0; #1;
    chk("arst_pc_hold", pc_hold, 1);
    chk("arst_pc_next", pc_next, 0);
    chk("arst_req_valid", imem_req_valid, 0);
    chk("arst_req_addr", imem_req_addr, 0);
    chk("arst_id_valid", id_valid, 0);
    chk("arst_id_instr", id_instr, 0);
    chk("arst_id_pc", id_pc, 0);

    // zero-wait imem: PC advances exactly on accepts, one instruction every three cycles
    lat_fix = 1; ready_mode = 1; idr_mode = 1;
    @(posedge clk); #2; rst_n = 1'b1;
    c0 = consumed; exp_next = 32'd4; last_acc = -1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin
        chk("zw_accept_pc_hold", pc_hold, 0);
        chk("zw_pc_next", pc_next, exp_next);
        exp_next = exp_next + 32'd4;
        if (last_acc >= 0) chk("zw_throughput", i - last_acc, 3);
        last_acc = i;
      end else begin
        chk("zw_idle_pc_hold", pc_hold, 1);
      end
    end
    chk("zw_consumed", consumed - c0 >= 3, 1);

    // FIFO full: fetch stops after DEPTH instructions and resumes at 0x8
    idr_mode = 0;
    do_reset();
    n0 = acc_log.size();
    repeat (30) @(negedge clk);
    chk("credit_accepts", acc_log.size() - n0, 2);
    chk("credit_req_valid", imem_req_valid, 0);
    chk("credit_pc_hold", pc_hold, 1);
    chk("credit_id_pc", id_pc, 0);
    idr_mode = 1;
    wait_accept(a);
    chk("credit_resume_addr", a, 32'h8);
    wait_consumed(3);

    // redirect during WAIT: queue flushed, outstanding response dropped
    idr_mode = 0; lat_fix = 4;
    do_reset();
    wait_accept(a);
    wait_accept(a);
    redirect(32'h100, 32'h100);
    idr_mode = 1;
    wait_accept(a);
    chk("wait_redir_next_addr", a, 32'h100);
    wait_consumed(2);

    // redirect while a request is stalled in ISSUE
    ready_mode = 0; lat_fix = 2;
    k = 0;
    do begin @(negedge clk); k++; end while (!imem_req_valid && k < 50);
    chk("issue_seen", imem_req_valid, 1);
    a0 = imem_req_addr;
    redirect(32'h200, 32'h200);
    repeat (3) @(negedge clk);
    chk("issue_held_addr", imem_req_addr, a0);
    ready_mode = 1;
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk); k++;
      if (imem_req_valid && imem_req_ready) begin
        seen = 1'b1;
        chk("stale_accept_pc_hold", pc_hold, 1);
        chk("stale_accept_addr", imem_req_addr, a0);
      end
    end
    chk("stale_accept_seen", seen, 1);
    @(posedge clk); #2;
    wait_accept(a);
    chk("issue_redir_next_addr", a, 32'h200);
    wait_consumed(2);

    // redirect in the same cycle as a response
    wait_accept(a);
    redirect(32'h300, 32'h300);
    wait_accept(a);
    chk("coincide_next_addr", a, 32'h300);
    wait_consumed(2);

    // table of redirect targets under random traffic (includes alignment and wrap cases)
    ready_mode = 2; idr_mode = 2; lat_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(3, 10)) @(posedge clk);
      redirect(vecs[i].rpc, vecs[i].exp_next);
      wait_consumed(2);
    end

    // random traffic with random redirects
    c0 = consumed;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        a = $urandom;
        a = {a[31:30], 18'd0, a[11:0]};
        redirect(a, a & ~32'd3);
      end else begin
        @(posedge clk);
      end
    end
    chk("random_progress", consumed - c0 > 50, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
